// File: rtl/text_console_ctrl.sv
// ---------------------------------------------------------------------------
// text_console_ctrl
//
// Owns the write port of the COLS x ROWS character grid RAM that the VGA
// text renderer reads. After reset it clears the whole grid and paints the
// "TELETYPE" title. It then accepts bytes over a valid/ready handshake and
// keeps a cursor inside a fixed text window. Printable bytes, backspace,
// line feed and form feed are interpreted, and each cell update is a single
// registered RAM write.
//
// Ports:
//   clk       system/pixel clock
//   reset     asynchronous, active-low reset
//   in_valid  byte available from the keyboard/UART path
//   in_data   ASCII byte
//   in_ready  block accepts a byte this cycle (IDLE only)
//   wr_en     grid RAM write strobe (registered)
//   wr_addr   row*COLS+col of the write (registered, held when wr_en=0)
//   wr_data   character code to write (registered, held when wr_en=0)
//   cur_x     cursor column
//   cur_y     cursor row
//   busy      high while an init or window-clear sweep is running
// ---------------------------------------------------------------------------
module text_console_ctrl #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int WIN_X0 = 20,
    parameter int WIN_X1 = 59,
    parameter int WIN_Y0 = 8,
    parameter int WIN_Y1 = 24,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [6:0]        cur_x,
    output logic [4:0]        cur_y,
    output logic              busy
);

    // Window bounds and grid constants at the widths of the signals they
    // are compared with, so every comparison is width-matched.
    localparam logic [6:0]        X0        = 7'(WIN_X0);
    localparam logic [6:0]        X1        = 7'(WIN_X1);
    localparam logic [4:0]        Y0        = 5'(WIN_Y0);
    localparam logic [4:0]        Y1        = 5'(WIN_Y1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

    // The title sits on row 4, columns 36..43.
    localparam logic [6:0]        TITLE_COL = 7'd36;
    localparam logic [4:0]        TITLE_ROW = 5'd4;

    typedef enum logic [1:0] {
        INIT_CLR,
        INIT_TITLE,
        IDLE,
        WIN_CLR
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic [2:0]        title_idx, title_idx_nxt;
    logic [6:0]        sweep_x, sweep_x_nxt;
    logic [4:0]        sweep_y, sweep_y_nxt;
    logic [6:0]        cur_x_nxt;
    logic [4:0]        cur_y_nxt;
    logic              wr_en_nxt;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic [7:0]        wr_data_nxt;
    logic [6:0]        bs_x;
    logic [4:0]        bs_y;
    logic              accept;

    // Row*COLS is formed at the full address width so legal coordinates
    // never truncate.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] x,
                                                    input logic [4:0] y);
        return ADDR_W'(y) * COLS_A + ADDR_W'(x);
    endfunction

    // Row advance wraps back to the top of the window; there is no scroll.
    function automatic logic [4:0] next_row(input logic [4:0] y);
        return (y < Y1) ? y + 5'd1 : Y0;
    endfunction

    function automatic logic [7:0] title_char(input logic [2:0] idx);
        logic [7:0] c;
        c = 8'h00;
        case (idx)
            3'd0: c = 8'h54;  // T
            3'd1: c = 8'h45;  // E
            3'd2: c = 8'h4C;  // L
            3'd3: c = 8'h45;  // E
            3'd4: c = 8'h54;  // T
            3'd5: c = 8'h59;  // Y
            3'd6: c = 8'h50;  // P
            3'd7: c = 8'h45;  // E
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

    // State, sweep counters, cursor and the registered RAM write port.
    // Reset aborts any sweep or write in flight and restarts the init clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= INIT_CLR;
            clr_cnt   <= '0;
            title_idx <= '0;
            sweep_x   <= X0;
            sweep_y   <= Y0;
            cur_x     <= X0;
            cur_y     <= Y0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state     <= state_nxt;
            clr_cnt   <= clr_cnt_nxt;
            title_idx <= title_idx_nxt;
            sweep_x   <= sweep_x_nxt;
            sweep_y   <= sweep_y_nxt;
            cur_x     <= cur_x_nxt;
            cur_y     <= cur_y_nxt;
            wr_en     <= wr_en_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_data   <= wr_data_nxt;
        end
    end

    // Next-state and next-write logic. The write address/data registers
    // hold their previous contents unless a write is issued, so the RAM
    // port is quiet between writes.
    always_comb begin
        state_nxt     = state;
        clr_cnt_nxt   = clr_cnt;
        title_idx_nxt = title_idx;
        sweep_x_nxt   = sweep_x;
        sweep_y_nxt   = sweep_y;
        cur_x_nxt     = cur_x;
        cur_y_nxt     = cur_y;
        wr_en_nxt     = 1'b0;
        wr_addr_nxt   = wr_addr;
        wr_data_nxt   = wr_data;

        // Backspace target: step left, or to the end of the previous row,
        // or stay put in the top-left corner of the window.
        bs_x = cur_x;
        bs_y = cur_y;
        if (cur_x > X0) begin
            bs_x = cur_x - 7'd1;
        end else if (cur_y > Y0) begin
            bs_x = X1;
            bs_y = cur_y - 5'd1;
        end

        case (state)
            INIT_CLR: begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = clr_cnt;
                wr_data_nxt = 8'h00;
                if (clr_cnt == LAST_CELL) begin
                    clr_cnt_nxt = '0;
                    state_nxt   = INIT_TITLE;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end

            INIT_TITLE: begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = cell_addr(TITLE_COL + {4'b0000, title_idx}, TITLE_ROW);
                wr_data_nxt = title_char(title_idx);
                if (title_idx == 3'd7) begin
                    title_idx_nxt = 3'd0;
                    state_nxt     = IDLE;
                end else begin
                    title_idx_nxt = title_idx + 3'd1;
                end
            end

            IDLE: begin
                if (accept) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = cell_addr(cur_x, cur_y);
                        wr_data_nxt = in_data;
                        if (cur_x < X1) begin
                            cur_x_nxt = cur_x + 7'd1;
                        end else begin
                            cur_x_nxt = X0;
                            cur_y_nxt = next_row(cur_y);
                        end
                    end else if (in_data == 8'h0A) begin
                        cur_x_nxt = X0;
                        cur_y_nxt = next_row(cur_y);
                    end else if (in_data == 8'h08) begin
                        cur_x_nxt   = bs_x;
                        cur_y_nxt   = bs_y;
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = cell_addr(bs_x, bs_y);
                        wr_data_nxt = 8'h00;
                    end else if (in_data == 8'h0C) begin
                        state_nxt   = WIN_CLR;
                        sweep_x_nxt = X0;
                        sweep_y_nxt = Y0;
                    end
                end
            end

            WIN_CLR: begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = cell_addr(sweep_x, sweep_y);
                wr_data_nxt = 8'h00;
                if (sweep_x == X1) begin
                    sweep_x_nxt = X0;
                    if (sweep_y == Y1) begin
                        sweep_y_nxt = Y0;
                        cur_x_nxt   = X0;
                        cur_y_nxt   = Y0;
                        state_nxt   = IDLE;
                    end else begin
                        sweep_y_nxt = sweep_y + 5'd1;
                    end
                end else begin
                    sweep_x_nxt = sweep_x + 7'd1;
                end
            end

            default: begin
                state_nxt = INIT_CLR;
            end
        endcase
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// ---------------------------------------------------------------------------
// tb_text_console_ctrl
//
// Self-checking bench for text_console_ctrl. The reference model holds the
// cursor as a linear position 0..679 inside the 40x17 text window and
// derives columns, rows and RAM addresses from it with plain arithmetic.
// A shadow grid is filled from the DUT's write port and compared with the
// grid the model expects at the end.
// ---------------------------------------------------------------------------
module tb_text_console_ctrl;

    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int ADDR_W = 12;
    localparam int NCELLS = COLS * ROWS;
    localparam int WX0    = 20;
    localparam int WY0    = 8;
    localparam int WW     = 40;
    localparam int WH     = 17;
    localparam int WCELLS = WW * WH;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [6:0]        cur_x;
    logic [4:0]        cur_y;
    logic              busy;

    text_console_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cur_x    (cur_x),
        .cur_y    (cur_y),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         sx;
        int         sy;
        logic [7:0] b;
        logic       we;
        int         addr;
        logic [7:0] data;
        int         ex;
        int         ey;
    } vec_t;

    vec_t       vecs[13];
    logic [7:0] title[8] = '{8'h54, 8'h45, 8'h4C, 8'h45, 8'h54, 8'h59, 8'h50, 8'h45};
    logic [7:0] tb_ram[NCELLS];
    logic [7:0] exp_ram[NCELLS];
    int         stray = 0;
    int         total = 0;
    int         bad = 0;
    int         pos = 0;
    int         last_addr = 0;
    logic [7:0] last_data = 8'h00;

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: time limit reached before the test finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int win_addr(input int p);
        return (WY0 + p / WW) * COLS + WX0 + p % WW;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            if (bad <= 40)
                $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge; record any
    // write into the shadow grid.
    task automatic tick();
        @(posedge clk);
        #1;
        if (wr_en === 1'b1) begin
            if (int'(wr_addr) < NCELLS) tb_ram[wr_addr] = wr_data;
            else stray++;
        end
    endtask

    task automatic checkCursor(input string tag);
        checkOutput({tag, "_cur_x"}, 32'(cur_x), WX0 + pos % WW);
        checkOutput({tag, "_cur_y"}, 32'(cur_y), WY0 + pos / WW);
    endtask

    task automatic expectInit();
        for (int i = 0; i < NCELLS; i++) begin
            tick();
            checkOutput("init_wr_en", 32'(wr_en), 1);
            checkOutput("init_addr", 32'(wr_addr), i);
            checkOutput("init_data", 32'(wr_data), 0);
            checkOutput("init_ready", 32'(in_ready), 0);
            exp_ram[i] = 8'h00;
        end
        for (int j = 0; j < 8; j++) begin
            tick();
            checkOutput("title_wr_en", 32'(wr_en), 1);
            checkOutput("title_addr", 32'(wr_addr), 4 * COLS + 36 + j);
            checkOutput("title_data", 32'(wr_data), 32'(title[j]));
            checkOutput("title_ready", 32'(in_ready), (j == 7) ? 1 : 0);
            checkOutput("title_busy", 32'(busy), (j == 7) ? 0 : 1);
            exp_ram[4 * COLS + 36 + j] = title[j];
        end
        last_addr = 4 * COLS + 36 + 7;
        last_data = title[7];
        pos = 0;
        checkCursor("init_end");
    endtask

    task automatic expectWinClear(input logic offer);
        in_valid = offer;
        in_data  = 8'h51;
        for (int k = 0; k < WCELLS; k++) begin
            tick();
            checkOutput("clr_wr_en", 32'(wr_en), 1);
            checkOutput("clr_addr", 32'(wr_addr), win_addr(k));
            checkOutput("clr_data", 32'(wr_data), 0);
            checkOutput("clr_ready", 32'(in_ready), (k == WCELLS - 1) ? 1 : 0);
            exp_ram[win_addr(k)] = 8'h00;
        end
        in_valid  = 1'b0;
        last_addr = win_addr(WCELLS - 1);
        last_data = 8'h00;
        pos = 0;
        checkCursor("clr_end");
    endtask

    // Offer one byte (valid stays high so calls chain back-to-back) and
    // check the cycle that follows against the window model.
    task automatic applyStimulus(input logic [7:0] b);
        int         new_pos;
        logic       we;
        logic       clr;
        int         a;
        logic [7:0] d;
        in_valid = 1'b1;
        in_data  = b;
        new_pos  = pos;
        we  = 1'b0;
        clr = 1'b0;
        a   = last_addr;
        d   = last_data;
        if (b >= 8'h20 && b <= 8'h7E) begin
            we = 1'b1;
            a  = win_addr(pos);
            d  = b;
            new_pos = (pos + 1) % WCELLS;
        end else if (b == 8'h0A) begin
            new_pos = ((pos / WW + 1) % WH) * WW;
        end else if (b == 8'h08) begin
            new_pos = (pos > 0) ? pos - 1 : 0;
            we = 1'b1;
            a  = win_addr(new_pos);
            d  = 8'h00;
        end else if (b == 8'h0C) begin
            clr = 1'b1;
        end
        tick();
        if (we) begin
            last_addr  = a;
            last_data  = d;
            exp_ram[a] = d;
        end
        pos = new_pos;
        checkOutput("byte_wr_en", 32'(wr_en), 32'(we));
        checkOutput("byte_addr", 32'(wr_addr), last_addr);
        checkOutput("byte_data", 32'(wr_data), 32'(last_data));
        checkOutput("byte_ready", 32'(in_ready), clr ? 0 : 1);
        if (!clr) checkCursor("byte");
        if (clr) expectWinClear(1'b0);
    endtask

    task automatic idleCycle();
        in_valid = 1'b0;
        tick();
        checkOutput("idle_wr_en", 32'(wr_en), 0);
        checkOutput("idle_addr_hold", 32'(wr_addr), last_addr);
        checkOutput("idle_data_hold", 32'(wr_data), 32'(last_data));
        checkCursor("idle");
    endtask

    task automatic moveTo(input int x, input int y);
        int t;
        int guard;
        t = (y - WY0) * WW + (x - WX0);
        guard = 0;
        while (pos != t && guard < 200) begin
            if (pos / WW != t / WW || pos % WW > t % WW) applyStimulus(8'h0A);
            else applyStimulus(8'h20);
            guard++;
        end
    endtask

    initial begin
        int diff;
        int r;
        logic [7:0] b;

        vecs[0]  = '{20,  8, 8'h41, 1'b1,  660, 8'h41, 21,  8};
        vecs[1]  = '{30, 10, 8'h0A, 1'b0,    0, 8'h00, 20, 11};
        vecs[2]  = '{20, 11, 8'h08, 1'b1,  859, 8'h00, 59, 10};
        vecs[3]  = '{20,  8, 8'h08, 1'b1,  660, 8'h00, 20,  8};
        vecs[4]  = '{59, 24, 8'h5A, 1'b1, 1979, 8'h5A, 20,  8};
        vecs[5]  = '{45, 15, 8'h07, 1'b0,    0, 8'h00, 45, 15};
        vecs[6]  = '{59, 24, 8'h0A, 1'b0,    0, 8'h00, 20,  8};
        vecs[7]  = '{59, 12, 8'h71, 1'b1, 1019, 8'h71, 20, 13};
        vecs[8]  = '{33, 17, 8'h08, 1'b1, 1392, 8'h00, 32, 17};
        vecs[9]  = '{20, 24, 8'h7E, 1'b1, 1940, 8'h7E, 21, 24};
        vecs[10] = '{40,  9, 8'h7F, 1'b0,    0, 8'h00, 40,  9};
        vecs[11] = '{40,  9, 8'h1F, 1'b0,    0, 8'h00, 40,  9};
        vecs[12] = '{40,  9, 8'h20, 1'b1,  760, 8'h20, 41,  9};

        for (int i = 0; i < NCELLS; i++) begin
            tb_ram[i]  = 8'hAA;
            exp_ram[i] = 8'h00;
        end

        $display("[TB] reset and power-up init");
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_wr_en", 32'(wr_en), 0);
        checkOutput("rst_addr", 32'(wr_addr), 0);
        checkOutput("rst_data", 32'(wr_data), 0);
        checkOutput("rst_ready", 32'(in_ready), 0);
        checkOutput("rst_busy", 32'(busy), 1);
        checkOutput("rst_cur_x", 32'(cur_x), 20);
        checkOutput("rst_cur_y", 32'(cur_y), 8);
        tick();
        tick();
        reset = 1'b1;
        expectInit();

        $display("[TB] table vectors");
        for (int v = 0; v < 13; v++) begin
            moveTo(vecs[v].sx, vecs[v].sy);
            applyStimulus(vecs[v].b);
            checkOutput($sformatf("vec%0d_wr_en", v), 32'(wr_en), 32'(vecs[v].we));
            if (vecs[v].we) begin
                checkOutput($sformatf("vec%0d_addr", v), 32'(wr_addr), vecs[v].addr);
                checkOutput($sformatf("vec%0d_data", v), 32'(wr_data), 32'(vecs[v].data));
            end
            checkOutput($sformatf("vec%0d_cur_x", v), 32'(cur_x), vecs[v].ex);
            checkOutput($sformatf("vec%0d_cur_y", v), 32'(cur_y), vecs[v].ey);
        end

        $display("[TB] form feed then 40 bytes back-to-back");
        applyStimulus(8'h0C);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(8'($urandom_range(33, 126)));
            checkOutput("b2b_addr", 32'(wr_addr), 660 + i);
        end
        idleCycle();
        checkOutput("b2b_cur_x", 32'(cur_x), 20);
        checkOutput("b2b_cur_y", 32'(cur_y), 9);

        $display("[TB] random byte stream");
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 15) begin
                idleCycle();
            end else begin
                r = $urandom_range(0, 199);
                if (r < 140)      b = 8'($urandom_range(32, 126));
                else if (r < 160) b = 8'h0A;
                else if (r < 180) b = 8'h08;
                else if (r < 198) b = 8'($urandom_range(127, 255));
                else              b = 8'h0C;
                applyStimulus(b);
            end
        end
        idleCycle();

        $display("[TB] reset during window clear");
        in_valid = 1'b1;
        in_data  = 8'h0C;
        tick();
        checkOutput("ff_ready", 32'(in_ready), 0);
        checkOutput("ff_wr_en", 32'(wr_en), 0);
        in_data = 8'h42;
        for (int k = 0; k < 100; k++) begin
            tick();
            checkOutput("part_clr_addr", 32'(wr_addr), win_addr(k));
        end
        #2 reset = 1'b0;
        #1;
        checkOutput("midrst_wr_en", 32'(wr_en), 0);
        checkOutput("midrst_busy", 32'(busy), 1);
        checkOutput("midrst_ready", 32'(in_ready), 0);
        checkOutput("midrst_cur_x", 32'(cur_x), 20);
        checkOutput("midrst_cur_y", 32'(cur_y), 8);
        tick();
        tick();
        reset = 1'b1;
        expectInit();
        applyStimulus(8'h42);
        checkOutput("held_byte_addr", 32'(wr_addr), 660);
        checkOutput("held_byte_data", 32'(wr_data), 32'h42);
        for (int n = 0; n < 20; n++) applyStimulus(8'($urandom_range(32, 126)));
        idleCycle();

        diff = 0;
        for (int i = 0; i < NCELLS; i++)
            if (tb_ram[i] !== exp_ram[i]) diff++;
        checkOutput("grid_cells_differing", diff, 0);
        checkOutput("writes_out_of_grid", stray, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
